decode_hz: RTL

Registered MIPS instruction-decode stage with load-use hazard detection, flush and downstream-stall handling. Sits between the fetch stage and the execute stage. It decodes one instruction per cycle into a pipeline register holding control signals, register addresses, an extended immediate and the PC. It also inserts a bubble and back-pressures fetch when the instruction it holds is a load whose destination is read by the incoming instruction.

---
 rtl/decode_hz.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/decode_hz.sv
// decode_hz: registered instruction-decode stage with load-use hazard
// detection. Decodes one instruction per cycle into a pipeline register,
// squashes on flush, holds on downstream stall and inserts one bubble
// when the held load writes a register the incoming instruction reads.
module decode_hz #(
  parameter int AWIDTH    = 5,
  parameter int IWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int PCWIDTH   = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic               d_clk,
  input  logic               d_rst,
  input  logic               d_i_ce,
  input  logic [IWIDTH-1:0]  d_i_instr,
  input  logic [PCWIDTH-1:0] d_i_pc,
  input  logic               d_i_flush,
  input  logic               d_i_stall,
  output logic               d_o_stall,
  output logic               d_o_ce,
  output logic [5:0]         d_o_opcode,
  output logic [5:0]         d_o_funct,
  output logic [AWIDTH-1:0]  d_o_addr_rs,
  output logic [AWIDTH-1:0]  d_o_addr_rt,
  output logic [AWIDTH-1:0]  d_o_addr_rd,
  output logic [DWIDTH-1:0]  d_o_imm,
  output logic [PCWIDTH-1:0] d_o_pc,
  output logic               d_o_reg_dst,
  output logic               d_o_reg_wr,
  output logic               d_o_alu_src,
  output logic               d_o_branch,
  output logic               d_o_bne,
  output logic               d_o_jump,
  output logic               d_o_memread,
  output logic               d_o_memwrite,
  output logic               d_o_memtoreg,
  output logic               d_o_illegal
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BNE  = 6'd7;
  localparam logic [5:0] OP_ORI  = 6'd8;

  // control bit order: reg_dst reg_wr alu_src branch bne jump memread memwrite memtoreg
  localparam int NCTL = 9;

  logic [5:0]           in_opcode;
  logic [5:0]           in_funct;
  logic [AWIDTH-1:0]    in_rs;
  logic [AWIDTH-1:0]    in_rt;
  logic [AWIDTH-1:0]    in_rd;
  logic [IMM_WIDTH-1:0] in_imm;

  assign in_opcode = d_i_instr[31:26];
  assign in_funct  = d_i_instr[5:0];
  assign in_rs     = d_i_instr[25:21];
  assign in_rt     = d_i_instr[20:16];
  assign in_rd     = d_i_instr[15:11];
  assign in_imm    = d_i_instr[IMM_WIDTH-1:0];

  logic [NCTL-1:0]   dec_ctl;
  logic              dec_illegal;
  logic              dec_rs_used;
  logic              dec_rt_used;
  logic [DWIDTH-1:0] dec_imm;

  // Decode the incoming instruction into controls, extended immediate and register usage.
  always_comb begin
    dec_ctl     = '0;
    dec_illegal = 1'b0;
    dec_rs_used = 1'b0;
    dec_rt_used = 1'b0;
    dec_imm     = {{(DWIDTH-IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm};
    case (in_opcode)
      OP_R:    begin dec_ctl = 9'b110000000; dec_rs_used = 1'b1; dec_rt_used = 1'b1; end
      OP_J:    begin
        dec_ctl = 9'b000001000;
        dec_imm = {{(DWIDTH-26){1'b0}}, d_i_instr[25:0]};
      end
      OP_BEQ:  begin dec_ctl = 9'b000100000; dec_rs_used = 1'b1; dec_rt_used = 1'b1; end
      OP_BNE:  begin dec_ctl = 9'b000110000; dec_rs_used = 1'b1; dec_rt_used = 1'b1; end
      OP_ADDI: begin dec_ctl = 9'b011000000; dec_rs_used = 1'b1; end
      OP_ORI:  begin
        dec_ctl     = 9'b011000000;
        dec_rs_used = 1'b1;
        dec_imm     = {{(DWIDTH-IMM_WIDTH){1'b0}}, in_imm};
      end
      OP_LW:   begin dec_ctl = 9'b011000101; dec_rs_used = 1'b1; end
      OP_SW:   begin dec_ctl = 9'b001000010; dec_rs_used = 1'b1; dec_rt_used = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic hazard;

  // A held load whose nonzero destination feeds the incoming instruction forces one bubble.
  always_comb begin
    hazard = d_o_ce & d_o_memread & (d_o_addr_rt != '0) & d_i_ce &
             ((dec_rs_used & (in_rs == d_o_addr_rt)) |
              (dec_rt_used & (in_rt == d_o_addr_rt)));
  end

  assign d_o_stall = d_i_stall | (hazard & ~d_i_flush);

  logic [NCTL-1:0] ctl_q;

  assign {d_o_reg_dst, d_o_reg_wr, d_o_alu_src, d_o_branch, d_o_bne,
          d_o_jump, d_o_memread, d_o_memwrite, d_o_memtoreg} = ctl_q;

  // Pipeline register: reset > flush > stall hold > hazard bubble > load > bubble.
  always_ff @(posedge d_clk) begin
    if (!d_rst) begin
      ctl_q       <= '0;
      d_o_ce      <= 1'b0;
      d_o_illegal <= 1'b0;
      d_o_opcode  <= '0;
      d_o_funct   <= '0;
      d_o_addr_rs <= '0;
      d_o_addr_rt <= '0;
      d_o_addr_rd <= '0;
      d_o_imm     <= '0;
      d_o_pc      <= '0;
    end else if (d_i_flush || (!d_i_stall && (hazard || !d_i_ce))) begin
      ctl_q       <= '0;
      d_o_ce      <= 1'b0;
      d_o_illegal <= 1'b0;
    end else if (!d_i_stall) begin
      // Illegal opcodes still load their fields but arrive as a flagged bubble.
      ctl_q       <= dec_illegal ? '0 : dec_ctl;
      d_o_ce      <= ~dec_illegal;
      d_o_illegal <= dec_illegal;
      d_o_opcode  <= in_opcode;
      d_o_funct   <= in_funct;
      d_o_addr_rs <= in_rs;
      d_o_addr_rt <= in_rt;
      d_o_addr_rd <= in_rd;
      d_o_imm     <= dec_imm;
      d_o_pc      <= d_i_pc;
    end
  end

endmodule
